dp_ram_stream_reader: RTL and testbench

- Read-side engine for the synchronous dual-port activation RAM.
- On a start command it walks a contiguous, wrapping address range on one RAM port and turns the 1-cycle-latency read data into a valid/ready stream.
- Absorbs consumer backpressure without losing or duplicating words.
- Sits between the RAM's read port and the downstream compute or stream logic.

---
 rtl/dp_ram_stream_reader.sv | 91 +++++++++
 tb/tb_dp_ram_stream_reader.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/dp_ram_stream_reader.sv
// dp_ram_stream_reader: walks a wrapping RAM address range and streams the read data over valid/ready
module dp_ram_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int RAM_DEPTH  = 256,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;
  state_t                state, state_nx;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [LEN_WIDTH-1:0]  len_r, issued, accepted;
  logic                  inflight, pop, issue;
  logic [1:0]            cnt;
  logic [2:0]            occ;
  logic [DATA_WIDTH-1:0] head, tail;
  assign pop       = out_valid & out_ready;
  assign occ       = {1'b0, cnt} + {2'b0, inflight} - {2'b0, pop};
  assign issue     = (state == RUN) && (issued != len_r) && (occ < 3'd2);
  assign busy      = state != IDLE;
  assign done      = state == FIN;
  assign ram_addr  = ptr;
  assign ram_we    = 1'b0;
  assign out_data  = head;
  assign out_valid = cnt != 2'd0;
  assign out_last  = out_valid && (accepted == len_r - LEN_WIDTH'(1));
  // next state: the last word leaving the buffer is the only way out of DRAIN
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? ((length == '0) ? FIN : RUN) : IDLE;
      RUN:     state_nx = (issued == len_r) ? DRAIN : RUN;
      DRAIN:   state_nx = (pop && out_last) ? FIN : DRAIN;
      default: state_nx = IDLE;
    endcase
  end
  // command latch, wrapping address pointer, issue/accept counters and read-in-flight flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      ptr      <= '0;
      len_r    <= '0;
      issued   <= '0;
      accepted <= '0;
      inflight <= 1'b0;
    end else begin
      state    <= state_nx;
      inflight <= issue;
      if (state == IDLE && start) begin
        ptr      <= base_addr;
        len_r    <= length;
        issued   <= '0;
        accepted <= '0;
      end
      if (issue) begin
        ptr    <= (ptr == ADDR_WIDTH'(RAM_DEPTH - 1)) ? '0 : ptr + ADDR_WIDTH'(1);
        issued <= issued + LEN_WIDTH'(1);
      end
      if (pop) accepted <= accepted + LEN_WIDTH'(1);
    end
  end
  // two-entry shift FIFO: pop shifts tail to head, push lands in the first free slot after the pop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= 2'd0;
      head <= '0;
      tail <= '0;
    end else begin
      cnt <= occ[1:0];
      if (pop) head <= tail;
      if (inflight) begin
        if (cnt == {1'b0, pop}) head <= ram_q;
        else tail <= ram_q;
      end
    end
  end
endmodule

// File: tb/tb_dp_ram_stream_reader.sv
// tb_dp_ram_stream_reader: directed scoreboard bench for the RAM stream reader
module tb_dp_ram_stream_reader;
  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;
  logic       start0 = 0, busy0, done0, we0, valid0, ready0 = 1, last0;
  logic [7:0] base0 = 0, addr0, q0 = 0, data0;
  logic [8:0] len0 = 0;
  logic       start1 = 0, busy1, done1, we1, valid1, ready1 = 1, last1;
  logic [7:0] base1 = 0, addr1, q1 = 0, data1;
  logic [8:0] len1 = 0;
  logic [7:0] mem1 [12];
  logic [8:0] sb0 [$], sb1 [$];
  int         alog [$];
  int         checks = 0, errors = 0, ndone0 = 0, last_a1 = 0;
  logic       stall0 = 0, stall1 = 0;
  logic [7:0] hold0 = 0, hold1 = 0;
  dp_ram_stream_reader d0 (
    .clk(clk), .rst(rst), .start(start0), .base_addr(base0), .length(len0),
    .busy(busy0), .done(done0), .ram_addr(addr0), .ram_we(we0), .ram_q(q0),
    .out_data(data0), .out_valid(valid0), .out_ready(ready0), .out_last(last0));
  dp_ram_stream_reader #(.RAM_DEPTH(12)) d1 (
    .clk(clk), .rst(rst), .start(start1), .base_addr(base1), .length(len1),
    .busy(busy1), .done(done1), .ram_addr(addr1), .ram_we(we1), .ram_q(q1),
    .out_data(data1), .out_valid(valid1), .out_ready(ready1), .out_last(last1));
  always @(posedge clk) q0 <= addr0;
  always @(posedge clk) q1 <= (addr1 < 8'd12) ? mem1[addr1] : 8'h00;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_done0(input int lim);
    for (int i = 0; i < lim && !done0; i++) step();
    chk("done0_timeout", done0, 1);
  endtask
  always @(negedge clk) begin
    if (done0) ndone0++;
    if (!rst) stall0 = 0;
    else begin
      if (stall0) chk("hold0", {valid0, data0}, {1'b1, hold0});
      if (valid0 && ready0) begin
        checks++;
        assert (sb0.size() != 0) else begin
          errors++;
          $error("FAIL extra0 observed=%0d expected=none", data0);
        end
        if (sb0.size() != 0) chk("word0", {last0, data0}, sb0.pop_front());
      end
      chk("fifo_cnt0", d0.cnt <= 2'd2, 1);
      stall0 = valid0 && !ready0;
      hold0  = data0;
    end
  end
  always @(negedge clk) begin
    if (!rst) stall1 = 0;
    else begin
      if (busy1 && addr1 != last_a1[7:0]) begin
        alog.push_back(int'(addr1));
        last_a1 = int'(addr1);
      end
      if (stall1) chk("hold1", {valid1, data1}, {1'b1, hold1});
      if (valid1 && ready1) begin
        checks++;
        assert (sb1.size() != 0) else begin
          errors++;
          $error("FAIL extra1 observed=%0d expected=none", data1);
        end
        if (sb1.size() != 0) chk("word1", {last1, data1}, sb1.pop_front());
      end
      stall1 = valid1 && !ready1;
      hold1  = data1;
    end
  end
  initial begin
    int nd;
    int ea [5];
    ea = '{10, 11, 0, 1, 2};
    for (int i = 0; i < 12; i++) mem1[i] = 8'(i * 7 + 3);
    #1;
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_valid", valid0, 0);
    chk("rst_last", last0, 0);
    chk("rst_addr", addr0, 0);
    chk("rst_data", data0, 0);
    chk("ram_we", we0, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1;
    // full-throughput command
    base0 = 10; len0 = 4; start0 = 1;
    for (int i = 10; i < 14; i++) sb0.push_back({i == 13, 8'(i)});
    step(); start0 = 0;
    chk("t1_busy", busy0, 1);
    chk("t1_e0_valid", valid0, 0);
    step();
    chk("t1_e1_valid", valid0, 0);
    step();
    chk("t1_e2_valid", valid0, 1);
    chk("t1_d10", data0, 10);
    step(); chk("t1_d11", data0, 11);
    step(); chk("t1_d12", data0, 12);
    step(); chk("t1_d13", data0, 13);
    chk("t1_last", last0, 1);
    step();
    chk("t1_done", done0, 1);
    chk("t1_valid_off", valid0, 0);
    step();
    chk("t1_done_off", done0, 0);
    chk("t1_busy_off", busy0, 0);
    chk("t1_sb_empty", sb0.size(), 0);
    // random backpressure
    for (int i = 10; i < 14; i++) sb0.push_back({i == 13, 8'(i)});
    start0 = 1;
    step(); start0 = 0;
    for (int i = 0; i < 200 && !done0; i++) begin
      ready0 = 1'($urandom_range(0, 1));
      step();
    end
    chk("t2_done", done0, 1);
    ready0 = 1;
    step();
    chk("t2_sb_empty", sb0.size(), 0);
    // zero length
    len0 = 0; start0 = 1;
    step(); start0 = 0;
    chk("t3_done", done0, 1);
    chk("t3_busy", busy0, 1);
    chk("t3_valid", valid0, 0);
    step();
    chk("t3_done_off", done0, 0);
    chk("t3_busy_off", busy0, 0);
    chk("t3_valid_off", valid0, 0);
    // start pulsed mid-command
    base0 = 20; len0 = 6; start0 = 1;
    for (int i = 20; i < 26; i++) sb0.push_back({i == 25, 8'(i)});
    step(); start0 = 0;
    nd = ndone0;
    step(); step();
    base0 = 50; len0 = 2; start0 = 1;
    step(); start0 = 0;
    repeat (20) step();
    chk("t4_one_done", ndone0 - nd, 1);
    chk("t4_sb_empty", sb0.size(), 0);
    // non-power-of-two wrap
    base1 = 10; len1 = 5; start1 = 1;
    for (int i = 0; i < 5; i++) sb1.push_back({i == 4, mem1[ea[i]]});
    step(); start1 = 0;
    for (int i = 0; i < 50 && !done1; i++) step();
    chk("t5_done", done1, 1);
    step();
    chk("t5_addr_count", alog.size() >= 5, 1);
    for (int i = 0; i < 5 && i < alog.size(); i++) chk("t5_addr", alog[i], ea[i]);
    chk("t5_sb_empty", sb1.size(), 0);
    // reset mid-command
    base0 = 100; len0 = 8; start0 = 1;
    for (int i = 100; i < 108; i++) sb0.push_back({i == 107, 8'(i)});
    step(); start0 = 0;
    step(); step(); step(); step();
    ready0 = 0; rst = 0;
    #1;
    chk("t6_valid", valid0, 0);
    chk("t6_busy", busy0, 0);
    chk("t6_done", done0, 0);
    sb0.delete();
    nd = ndone0;
    step();
    rst = 1; ready0 = 1;
    base0 = 0; len0 = 3; start0 = 1;
    for (int i = 0; i < 3; i++) sb0.push_back({i == 2, 8'(i)});
    step(); start0 = 0;
    wait_done0(50);
    step();
    chk("t6_sb_empty", sb0.size(), 0);
    chk("t6_one_done", ndone0 - nd, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
